// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - frames ACC_COUNT adder sums into one total with valid/ready handshakes.
// Optional synchronous clear port enabled by defining SUM_ACCUMULATOR_CLEAR_EN.
module sum_accumulator #(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_COUNT  = 8,
  localparam int ACC_WIDTH = DATA_WIDTH + 1 + $clog2(ACC_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef SUM_ACCUMULATOR_CLEAR_EN
  input  logic                          clr,
`endif
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH:0]           in_sum,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_WIDTH-1:0]          out_total,
  output logic [$clog2(ACC_COUNT):0]    beat_cnt
);

  localparam int CNT_W = $clog2(ACC_COUNT) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ACC_COUNT - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(ACC_COUNT);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] sum_ext;
  logic                 in_beat;
  logic                 out_beat;

  assign sum_ext  = {{(ACC_WIDTH-DATA_WIDTH-1){1'b0}}, in_sum};
  assign in_beat  = in_valid && in_ready;
  assign out_beat = out_valid && out_ready;

  // Handshake flags are registered alongside the state so neither depends
  // combinationally on the opposite side of the interface.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACCUM;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_total <= '0;
      beat_cnt  <= '0;
      acc       <= '0;
`ifdef SUM_ACCUMULATOR_CLEAR_EN
    end else if (clr) begin
      state     <= ACCUM;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      beat_cnt  <= '0;
      acc       <= '0;
`endif
    end else begin
      case (state)
        ACCUM: begin
          if (in_beat) begin
            if (beat_cnt == LAST_BEAT) begin
              out_total <= acc + sum_ext;
              beat_cnt  <= FULL_CNT;
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              acc      <= acc + sum_ext;
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_beat) begin
            acc       <= '0;
            beat_cnt  <= '0;
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ACCUM;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - directed self-checking bench for sum_accumulator.
// Clear-port step is included when SUM_ACCUMULATOR_CLEAR_EN is defined.
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_sum = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_total;
  logic [3:0] beat_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sum_accumulator #(.DATA_WIDTH(4), .ACC_COUNT(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef SUM_ACCUMULATOR_CLEAR_EN
    .clr(clr),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_sum(in_sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_total(out_total),
    .beat_cnt(beat_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] rdy, input logic [31:0] vld,
                             input logic [31:0] tot, input logic [31:0] cnt);
    check({tag, ".in_ready"}, {31'd0, in_ready}, rdy);
    check({tag, ".out_valid"}, {31'd0, out_valid}, vld);
    check({tag, ".out_total"}, {24'd0, out_total}, tot);
    check({tag, ".beat_cnt"}, {28'd0, beat_cnt}, cnt);
  endtask

  initial begin
    // Reset
    tick();
    check_state("reset", 1, 0, 0, 0);
    rst_n = 1'b1;

    // Eight beats of 30 with out_ready high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sum    = 5'd30;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("f30.beat_cnt", {28'd0, beat_cnt}, i);
    end
    tick();
    in_valid = 1'b0;
    check_state("f30.hold", 0, 1, 240, 8);
    tick();
    check_state("f30.drain", 1, 0, 240, 0);

    // Sums 1..8 with idle cycles between; held off afterwards
    out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_sum   = 5'(k);
      tick();
      in_valid = 1'b0;
      if (k < 8) begin
        check("seq.beat_cnt", {28'd0, beat_cnt}, k);
        tick();
        check("seq.idle_cnt", {28'd0, beat_cnt}, k);
        check("seq.idle_total", {24'd0, out_total}, 240);
      end
    end
    check_state("seq.hold", 0, 1, 36, 8);

    // Held-off frame while upstream keeps offering 7
    in_valid = 1'b1;
    in_sum   = 5'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_state("stall", 0, 1, 36, 8);
    end
    out_ready = 1'b1;
    tick();
    check_state("stall.release", 1, 0, 36, 0);
    in_sum = 5'd3;
    for (int i = 0; i < 8; i++) tick();
    in_valid = 1'b0;
    check_state("after_stall.hold", 0, 1, 24, 8);
    tick();
    check_state("after_stall.drain", 1, 0, 24, 0);

    // Reset mid-frame
    in_valid = 1'b1;
    in_sum   = 5'd10;
    for (int i = 0; i < 4; i++) tick();
    check("mid.beat_cnt", {28'd0, beat_cnt}, 4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_state("mid.reset", 1, 0, 0, 0);
    out_ready = 1'b0;
    in_sum    = 5'd2;
    for (int i = 0; i < 8; i++) tick();
    in_valid = 1'b0;
    check_state("post_reset.hold", 0, 1, 16, 8);

    // Reset while holding a pending total
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_state("hold.reset", 1, 0, 0, 0);

    // Back-to-back frames: exactly one HOLD cycle between them
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sum    = 5'd30;
    for (int i = 0; i < 8; i++) tick();
    in_sum = 5'd0;
    check_state("b2b.first", 0, 1, 240, 8);
    tick();
    check_state("b2b.gap", 1, 0, 240, 0);
    for (int i = 0; i < 7; i++) tick();
    check("b2b.pre_valid", {31'd0, out_valid}, 0);
    tick();
    check_state("b2b.second", 0, 1, 0, 8);
    in_valid = 1'b0;
    tick();
    check_state("b2b.done", 1, 0, 0, 0);

`ifdef SUM_ACCUMULATOR_CLEAR_EN
    // Clear coincident with the completing beat
    in_valid = 1'b1;
    in_sum   = 5'd5;
    for (int i = 0; i < 7; i++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_state("clr", 1, 0, 0, 0);
    in_sum = 5'd1;
    for (int i = 0; i < 8; i++) tick();
    in_valid = 1'b0;
    check_state("clr.next", 0, 1, 8, 8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
